// File: rtl/riscv_irq_arbiter.sv
// Interrupt source arbiter: registers and pends the core's interrupt lines and presents
// one fixed-priority request with a stable ID to riscv_int_controller.
module riscv_irq_arbiter #(
  parameter bit          PULP_SECURE  = 1'b0,
  parameter bit          FAST_EDGE    = 1'b1,
  parameter logic [17:0] SECURE_LINES = 18'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_software_i,
  input  logic        irq_timer_i,
  input  logic        irq_external_i,
  input  logic [14:0] irq_fast_i,
  input  logic        irq_nmi_i,
  input  logic [17:0] mie_i,
  output logic [17:0] mip_o,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_sec_o,
  input  logic        irq_ack_i,
  input  logic        irq_kill_i
);

  typedef enum logic [1:0] {IDLE, REQ, COOL} state_t;

  state_t      state;
  logic        sw_q, tmr_q, ext_q, nmi_q;
  logic [14:0] fast_q, fast_pend, fast_clr;
  logic        nmi_pend, nmi_clr;
  logic [17:0] pend, elig;
  logic        sel_valid, sel_nmi, sel_sec, still_elig;
  logic [4:0]  sel_id, sel_bit, lat_bit;
  logic        lat_nmi;

  assign pend  = {sw_q, tmr_q, ext_q, fast_pend};
  assign elig  = pend & mie_i;
  assign mip_o = pend;

  // Set terms come from the raw input against its registered copy, so a new edge
  // is visible in the pending register after the same edge that registers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q      <= 1'b0;
      tmr_q     <= 1'b0;
      ext_q     <= 1'b0;
      nmi_q     <= 1'b0;
      fast_q    <= '0;
      fast_pend <= '0;
      nmi_pend  <= 1'b0;
    end else begin
      sw_q     <= irq_software_i;
      tmr_q    <= irq_timer_i;
      ext_q    <= irq_external_i;
      nmi_q    <= irq_nmi_i;
      fast_q   <= irq_fast_i;
      nmi_pend <= (nmi_pend & ~nmi_clr) | (irq_nmi_i & ~nmi_q);
      if (FAST_EDGE)
        fast_pend <= (fast_pend & ~fast_clr) | (irq_fast_i & ~fast_q);
      else
        fast_pend <= irq_fast_i;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_nmi   = 1'b0;
    sel_id    = '0;
    sel_bit   = '0;
    if (nmi_pend) begin
      sel_valid = 1'b1;
      sel_nmi   = 1'b1;
      sel_id    = 5'd31;
    end else if (|elig[14:0]) begin
      sel_valid = 1'b1;
      for (int unsigned i = 0; i < 15; i++) begin
        if (elig[i]) begin
          sel_id  = 5'(16 + i);
          sel_bit = 5'(i);
        end
      end
    end else if (elig[15]) begin
      sel_valid = 1'b1;
      sel_id    = 5'd11;
      sel_bit   = 5'd15;
    end else if (elig[17]) begin
      sel_valid = 1'b1;
      sel_id    = 5'd3;
      sel_bit   = 5'd17;
    end else if (elig[16]) begin
      sel_valid = 1'b1;
      sel_id    = 5'd7;
      sel_bit   = 5'd16;
    end
  end

  assign sel_sec    = PULP_SECURE && !sel_nmi && SECURE_LINES[sel_bit];
  assign still_elig = lat_nmi || elig[lat_bit];

  always_comb begin
    fast_clr = '0;
    nmi_clr  = 1'b0;
    if (state == REQ && irq_ack_i) begin
      if (lat_nmi)
        nmi_clr = 1'b1;
      else if (lat_bit < 5'd15)
        fast_clr[lat_bit[3:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
      irq_sec_o <= 1'b0;
      lat_bit   <= '0;
      lat_nmi   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_valid) begin
          state     <= REQ;
          irq_o     <= 1'b1;
          irq_id_o  <= sel_id;
          irq_sec_o <= sel_sec;
          lat_bit   <= sel_bit;
          lat_nmi   <= sel_nmi;
        end
        REQ: if (irq_ack_i) begin
          state <= COOL;
          irq_o <= 1'b0;
        end else if (irq_kill_i || !still_elig) begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
        COOL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Randomized and directed bench for riscv_irq_arbiter against a line-list reference model.
module tb_riscv_irq_arbiter;

  localparam logic [17:0] SEC = 18'h28011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw = 1'b0, tmr = 1'b0, ext = 1'b0, nmi = 1'b0;
  logic [14:0] fast = '0;
  logic [17:0] mie = '0;
  logic        ack = 1'b0, kill = 1'b0;
  logic [17:0] mip;
  logic        irq, irq_sec;
  logic [4:0]  irq_id;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_irq_arbiter #(
    .PULP_SECURE(1'b1),
    .FAST_EDGE(1'b1),
    .SECURE_LINES(SEC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .irq_software_i(sw), .irq_timer_i(tmr), .irq_external_i(ext),
    .irq_fast_i(fast), .irq_nmi_i(nmi), .mie_i(mie),
    .mip_o(mip), .irq_o(irq), .irq_id_o(irq_id), .irq_sec_o(irq_sec),
    .irq_ack_i(ack), .irq_kill_i(kill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lines 0..14 fast, 15 ext, 16 timer, 17 sw; -1 denotes NMI.
  bit   m_pend[18];
  bit   m_nmi;
  bit   prev[19];
  bit   m_req, m_cool, m_sec;
  int   m_line;
  logic [4:0] m_id;
  int   prio[19] = '{-1, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15, 17, 16};

  function automatic logic [4:0] id_of(input int line);
    if (line < 0)  return 5'd31;
    if (line < 15) return 5'(16 + line);
    if (line == 15) return 5'd11;
    if (line == 16) return 5'd7;
    return 5'd3;
  endfunction

  function automatic logic [17:0] m_mip();
    logic [17:0] v;
    for (int i = 0; i < 18; i++) v[i] = m_pend[i];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        foreach (prev[i]) prev[i] = 1'b0;
        m_nmi = 0; m_req = 0; m_cool = 0; m_sec = 0; m_line = 0; m_id = '0;
      end else begin
        bit raw[19];
        bit clr[19];
        bit found;
        for (int i = 0; i < 15; i++) raw[i] = fast[i];
        raw[15] = ext; raw[16] = tmr; raw[17] = sw; raw[18] = nmi;
        foreach (clr[i]) clr[i] = 1'b0;
        if (m_req) begin
          if (ack) begin
            if (m_line < 0) clr[18] = 1'b1;
            else if (m_line < 15) clr[m_line] = 1'b1;
            m_req = 0; m_cool = 1;
          end else if (kill) begin
            m_req = 0;
          end else if (m_line >= 0 && !(m_pend[m_line] && mie[m_line])) begin
            m_req = 0;
          end
        end else if (m_cool) begin
          m_cool = 0;
        end else begin
          found = 0;
          foreach (prio[k]) begin
            if (!found && (prio[k] < 0 ? m_nmi : (m_pend[prio[k]] && mie[prio[k]]))) begin
              found  = 1;
              m_line = prio[k];
              m_id   = id_of(prio[k]);
              m_sec  = (prio[k] < 0) ? 1'b0 : SEC[prio[k]];
              m_req  = 1;
            end
          end
        end
        for (int i = 0; i < 15; i++)
          m_pend[i] = (m_pend[i] && !clr[i]) || (raw[i] && !prev[i]);
        for (int i = 15; i < 18; i++) m_pend[i] = raw[i];
        m_nmi = (m_nmi && !clr[18]) || (raw[18] && !prev[18]);
        foreach (prev[i]) prev[i] = raw[i];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_irq", 32'(irq), 32'(m_req));
      if (m_req) begin
        check("model_id", 32'(irq_id), 32'(m_id));
        check("model_sec", 32'(irq_sec), 32'(m_sec));
      end
      check("model_mip", 32'(mip), 32'(m_mip()));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic flush();
    sw = 0; tmr = 0; ext = 0; nmi = 0; fast = '0; kill = 0; mie = '1;
    ack = 1;
    tick(12);
    ack = 0;
    tick(2);
  endtask

  initial begin
    tick(2);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_mip", 32'(mip), 32'd0);
    rst_n = 1;

    // Timer: request two cycles later, re-request after the two-cycle gap.
    mie = '1; tmr = 1;
    tick();
    check("tmr_mip", 32'(mip[16]), 32'd1);
    check("tmr_early", 32'(irq), 32'd0);
    tick();
    check("tmr_irq", 32'(irq), 32'd1);
    check("tmr_id", 32'(irq_id), 32'd7);
    ack = 1;
    tick(); ack = 0;
    check("tmr_gap1", 32'(irq), 32'd0);
    tick();
    check("tmr_gap2", 32'(irq), 32'd0);
    tick();
    check("tmr_rereq", 32'(irq), 32'd1);
    check("tmr_reid", 32'(irq_id), 32'd7);
    flush();

    // Fast[3] beats external; ack clears the sticky fast bit.
    fast[3] = 1; ext = 1;
    tick(2);
    check("f3_id", 32'(irq_id), 32'd19);
    ack = 1; fast[3] = 0;
    tick(); ack = 0;
    check("f3_clr", 32'(mip[3]), 32'd0);
    tick(2);
    check("ext_irq", 32'(irq), 32'd1);
    check("ext_id", 32'(irq_id), 32'd11);
    flush();

    // NMI arriving during REQ does not preempt; it is taken even with mie=0.
    fast[0] = 1;
    tick(2);
    check("f0_id", 32'(irq_id), 32'd16);
    nmi = 1;
    tick(3);
    check("nopreempt", 32'(irq_id), 32'd16);
    mie = '0; ack = 1;
    tick(); ack = 0;
    tick(2);
    check("nmi_irq", 32'(irq), 32'd1);
    check("nmi_id", 32'(irq_id), 32'd31);
    check("nmi_sec", 32'(irq_sec), 32'd0);
    ack = 1;
    tick(); ack = 0;
    tick(3);
    check("nmi_cleared", 32'(irq), 32'd0);
    flush();

    // Withdrawal on mie drop, then kill leaves the pending bit alone.
    sw = 1;
    tick(2);
    check("sw_id", 32'(irq_id), 32'd3);
    check("sw_sec", 32'(irq_sec), 32'd1);
    mie[17] = 0;
    tick();
    check("sw_withdraw", 32'(irq), 32'd0);
    mie = '1;
    tick();
    check("sw_again", 32'(irq), 32'd1);
    kill = 1;
    tick(); kill = 0;
    check("kill_irq", 32'(irq), 32'd0);
    check("kill_mip", 32'(mip[17]), 32'd1);
    flush();

    // Ack and kill together behave as ack.
    fast[4] = 1;
    tick(2);
    check("f4_id", 32'(irq_id), 32'd20);
    ack = 1; kill = 1;
    tick(); ack = 0; kill = 0;
    check("ackkill_irq", 32'(irq), 32'd0);
    check("ackkill_mip", 32'(mip[4]), 32'd0);
    tick(2);
    check("ackkill_idle", 32'(irq), 32'd0);
    flush();

    // Asynchronous reset mid-request; secure external line.
    ext = 1;
    tick(2);
    check("ext_sec", 32'(irq_sec), 32'd1);
    #2 rst_n = 0;
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_id", 32'(irq_id), 32'd0);
    check("arst_mip", 32'(mip), 32'd0);
    check("arst_sec", 32'(irq_sec), 32'd0);
    tick(); rst_n = 1;
    tick();
    check("post_rst_early", 32'(irq), 32'd0);
    tick();
    check("post_rst_irq", 32'(irq), 32'd1);
    check("post_rst_id", 32'(irq_id), 32'd11);
    flush();

    // Random phase: model comparison every cycle.
    for (int c = 0; c < 3000; c++) begin
      fast = 15'($urandom & $urandom & $urandom);
      sw   = ($urandom_range(0, 3) == 0);
      tmr  = ($urandom_range(0, 3) == 0);
      ext  = ($urandom_range(0, 3) == 0);
      nmi  = ($urandom_range(0, 19) == 0);
      mie  = ($urandom_range(0, 7) == 0) ? 18'($urandom) : '1;
      ack  = ($urandom_range(0, 9) < 3);
      kill = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 0;
        #1 rst_n = 1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
